i2c_target_rx: RTL and testbench

Write-only I2C target (responder) for the FMC424 I2C path: the receive end of the bus whose SCL our 100 kHz controller clock generator drives. Oversamples SCL/SDA pad readback on CLK (50 MHz), detects START/STOP, matches a 7-bit address, ACKs by pulling SDA low, and delivers each received data byte to fabric as a one-cycle strobe. Used as an on-FPGA loopback target for controller bring-up and as a register-write sink.

---
 rtl/i2c_target_rx.sv | 97 +++++++++
 tb/tb_i2c_target_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
`timescale 1ns/1ps
// i2c_target_rx: oversampled write-only I2C target that ACKs ADDR and strobes out each received data byte
module i2c_target_rx #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);
  typedef enum logic [2:0] {st_idle, st_addr, st_addr_ack, st_data, st_data_ack, st_ignore} state_t;
  state_t state;
  logic [2:0] scl_s, sda_s, cnt;
  logic [6:0] sh;
  logic [7:0] byte_in;
  logic scl_hi, scl_rise, scl_fall, start, stop;
  assign scl_hi   = scl_s[1] & scl_s[2];
  assign scl_rise = scl_s[1] & ~scl_s[2];
  assign scl_fall = ~scl_s[1] & scl_s[2];
  assign start    = scl_hi & sda_s[2] & ~sda_s[1];
  assign stop     = scl_hi & ~sda_s[2] & sda_s[1];
  assign byte_in  = {sh, sda_s[1]};
  always_ff @(posedge CLK) begin
    if (!rst) begin
      scl_s <= 3'b111;
      sda_s <= 3'b111;
    end else begin
      scl_s <= {scl_s[1:0], scl_in};
      sda_s <= {sda_s[1:0], sda_in};
    end
  end
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state     <= st_idle;
      sh        <= '0;
      cnt       <= '0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (start) begin
        state     <= st_addr;
        cnt       <= '0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        start_det <= 1'b1;
      end else if (stop) begin
        state    <= st_idle;
        cnt      <= '0;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        stop_det <= 1'b1;
      end else begin
        case (state)
          st_addr, st_data: begin
            if (scl_rise) begin
              sh  <= byte_in[6:0];
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                if (state == st_data) begin
                  rx_data  <= byte_in;
                  rx_valid <= 1'b1;
                  state    <= st_data_ack;
                end else begin
                  state <= (sh == ADDR && !sda_s[1]) ? st_addr_ack : st_ignore;
                end
              end
            end
          end
          st_addr_ack, st_data_ack: begin
            if (scl_fall) begin
              sda_oe <= !sda_oe;
              if (sda_oe) begin
                busy  <= 1'b1;
                cnt   <= '0;
                state <= st_data;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target_rx.sv
`timescale 1ns/1ps
// tb_i2c_target_rx: bit-banged I2C controller with rx-byte scoreboard against i2c_target_rx
module tb_i2c_target_rx;
  logic CLK = 1'b0, rst = 1'b0, scl = 1'b1, sda_m = 1'b1;
  logic sda_bus, sda_oe, rx_valid, start_det, stop_det, busy;
  logic [7:0] rx_data;
  int q = 125;
  int vectors = 0, miscompares = 0;
  int start_cnt = 0, stop_cnt = 0, oe_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  assign sda_bus = sda_m & ~sda_oe;
  i2c_target_rx #(.ADDR(7'h50)) dut (
    .CLK(CLK), .rst(rst), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .start_det(start_det),
    .stop_det(stop_det), .busy(busy)
  );
  always #10 CLK = ~CLK;
  always @(negedge CLK) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (start_det) start_cnt++;
    if (stop_det) stop_cnt++;
    if (sda_oe) oe_cyc++;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish within 5 ms");
    $fatal(1);
  end
  task automatic wq(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic send_start();
    wq(q); sda_m = 1'b1; wq(q); scl = 1'b1; wq(2*q); sda_m = 1'b0; wq(2*q); scl = 1'b0;
  endtask
  task automatic send_stop();
    wq(q); sda_m = 1'b0; wq(q); scl = 1'b1; wq(2*q); sda_m = 1'b1; wq(2*q);
  endtask
  task automatic send_bit(input logic b);
    wq(q); sda_m = b; wq(q); scl = 1'b1; wq(2*q); scl = 1'b0;
  endtask
  task automatic write_byte(input logic [7:0] b, output logic [2:0] obs);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    repeat (2) @(posedge CLK);
    #1 obs[2] = sda_oe;
    @(posedge CLK);
    #1 obs[1] = sda_oe;
    @(negedge CLK);
    wq(q - 1); sda_m = 1'b1; wq(q); scl = 1'b1; wq(q); obs[0] = ~sda_bus; wq(q); scl = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    wq(4);
    vectors++;
    if ({sda_oe, rx_data, rx_valid, start_det, stop_det, busy} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 0", {sda_oe, rx_data, rx_valid, start_det, stop_det, busy});
    end
    rst = 1'b1;
    wq(10);
    vectors++;
    if (start_cnt + stop_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_no_events got %0d want 0", start_cnt + stop_cnt);
    end
  endtask
  task automatic test_write();
    logic [2:0] obs;
    logic [7:0] g, e;
    int s0 = start_cnt, p0 = stop_cnt;
    send_start();
    write_byte(8'hA0, obs);
    vectors++;
    if (obs !== 3'b011) begin miscompares++; $display("FAIL t1_addr_ack got %b want 011", obs); end
    wq(5);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL t1_busy_set got %b want 1", busy); end
    exp_q.push_back(8'h3C);
    write_byte(8'h3C, obs);
    vectors++;
    if (obs !== 3'b011) begin miscompares++; $display("FAIL t1_d0_ack got %b want 011", obs); end
    exp_q.push_back(8'hC3);
    write_byte(8'hC3, obs);
    vectors++;
    if (obs !== 3'b011) begin miscompares++; $display("FAIL t1_d1_ack got %b want 011", obs); end
    send_stop();
    wq(5);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = got_q.size() != 0 ? got_q.pop_front() : 8'hxx;
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL t1_rx got %h want %h", g, e); end
    end
    vectors++;
    if (got_q.size() != 0) begin miscompares++; $display("FAIL t1_stray_rx got %0d want 0", got_q.size()); got_q.delete(); end
    vectors++;
    if (start_cnt - s0 !== 1 || stop_cnt - p0 !== 1) begin
      miscompares++;
      $display("FAIL t1_start_stop got %0d/%0d want 1/1", start_cnt - s0, stop_cnt - p0);
    end
    vectors++;
    if (busy !== 1'b0 || rx_data !== 8'hC3) begin
      miscompares++;
      $display("FAIL t1_end_state got busy=%b rx=%h want busy=0 rx=c3", busy, rx_data);
    end
  endtask
  task automatic test_wrong_addr();
    logic [2:0] obs;
    int p0 = stop_cnt;
    send_start();
    write_byte(8'hA2, obs);
    vectors++;
    if (obs !== 3'b000) begin miscompares++; $display("FAIL t2_addr_nack got %b want 000", obs); end
    write_byte(8'h77, obs);
    vectors++;
    if (obs !== 3'b000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t2_ignore got obs=%b busy=%b want 000/0", obs, busy);
    end
    send_stop();
    wq(5);
    vectors++;
    if (got_q.size() != 0 || stop_cnt - p0 !== 1) begin
      miscompares++;
      $display("FAIL t2_rx_stop got rx=%0d stops=%0d want 0/1", got_q.size(), stop_cnt - p0);
      got_q.delete();
    end
  endtask
  task automatic test_read_nack();
    logic [2:0] obs;
    int o0 = oe_cyc;
    send_start();
    write_byte(8'hA1, obs);
    vectors++;
    if (obs !== 3'b000) begin miscompares++; $display("FAIL t3_read_nack got %b want 000", obs); end
    vectors++;
    if (oe_cyc !== o0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t3_no_drive got oe_cycles=%0d busy=%b want 0/0", oe_cyc - o0, busy);
    end
    send_stop();
    wq(5);
  endtask
  task automatic test_back_to_back();
    logic [2:0] obs;
    logic [7:0] g, e;
    int s0 = start_cnt;
    send_start();
    write_byte(8'hA0, obs);
    vectors++;
    if (obs !== 3'b011) begin miscompares++; $display("FAIL t4_addr0_ack got %b want 011", obs); end
    exp_q.push_back(8'h55);
    write_byte(8'h55, obs);
    vectors++;
    if (obs !== 3'b011) begin miscompares++; $display("FAIL t4_d0_ack got %b want 011", obs); end
    send_start();
    write_byte(8'hA0, obs);
    vectors++;
    if (obs !== 3'b011) begin miscompares++; $display("FAIL t4_addr1_ack got %b want 011", obs); end
    exp_q.push_back(8'hAA);
    write_byte(8'hAA, obs);
    vectors++;
    if (obs !== 3'b011) begin miscompares++; $display("FAIL t4_d1_ack got %b want 011", obs); end
    send_stop();
    wq(5);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = got_q.size() != 0 ? got_q.pop_front() : 8'hxx;
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL t4_rx got %h want %h", g, e); end
    end
    vectors++;
    if (start_cnt - s0 !== 2 || got_q.size() != 0) begin
      miscompares++;
      $display("FAIL t4_starts got %0d stray=%0d want 2/0", start_cnt - s0, got_q.size());
      got_q.delete();
    end
  endtask
  task automatic test_mid_reset();
    logic [2:0] obs;
    logic [7:0] g;
    send_start();
    write_byte(8'hA0, obs);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b0;
    wq(3);
    vectors++;
    if ({sda_oe, rx_data, rx_valid, start_det, stop_det, busy} !== 13'h0) begin
      miscompares++;
      $display("FAIL t5_reset_outputs got %b want 0", {sda_oe, rx_data, rx_valid, start_det, stop_det, busy});
    end
    scl = 1'b1;
    sda_m = 1'b1;
    wq(5);
    rst = 1'b1;
    wq(5);
    send_start();
    write_byte(8'hA0, obs);
    vectors++;
    if (obs !== 3'b011) begin miscompares++; $display("FAIL t5_addr_ack got %b want 011", obs); end
    exp_q.push_back(8'h12);
    write_byte(8'h12, obs);
    send_stop();
    wq(5);
    g = got_q.size() != 0 ? got_q.pop_front() : 8'hxx;
    vectors++;
    if (g !== exp_q.pop_front() || got_q.size() != 0) begin
      miscompares++;
      $display("FAIL t5_rx got %h stray=%0d want 12/0", g, got_q.size());
      got_q.delete();
    end
  endtask
  task automatic test_simultaneous();
    int s0 = start_cnt, p0 = stop_cnt;
    wq(10);
    scl = 1'b0; sda_m = 1'b0;
    wq(10);
    scl = 1'b1; sda_m = 1'b1;
    wq(10);
    vectors++;
    if (start_cnt !== s0) begin miscompares++; $display("FAIL t6_no_start got %0d want 0", start_cnt - s0); end
    vectors++;
    if (stop_cnt !== p0) begin miscompares++; $display("FAIL t6_no_stop got %0d want 0", stop_cnt - p0); end
  endtask
  initial begin
    test_reset();
    test_write();
    q = 8;
    test_wrong_addr();
    test_read_nack();
    test_back_to_back();
    test_mid_reset();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
